// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (sign fix-up on entry to DONE).
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    // ZERO is the single settling cycle of a divide-by-zero request; RUN is skipped
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] dvd_r, dvs_r, q_r, rem_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH:0]   rem_shift, trial;
    logic [WIDTH-1:0] rem_next, q_next;
    logic [WIDTH-1:0] load_dvd, load_dvs, fin_q, fin_r, zero_r;

    assign rem_shift = {1'b0, rem_r, q_r[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, dvs_r};
    assign rem_next  = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_next    = {q_r[WIDTH-2:0], ~trial[WIDTH]};

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic dvd_neg, quo_neg;

    assign load_dvd = dividend[WIDTH-1] ? -dividend : dividend;
    assign load_dvs = divisor[WIDTH-1] ? -divisor : divisor;
    assign fin_q    = quo_neg ? -q_next : q_next;
    assign fin_r    = dvd_neg ? -rem_next : rem_next;
    assign zero_r   = dvd_neg ? -dvd_r : dvd_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_neg <= 1'b0;
            quo_neg <= 1'b0;
        end else if (state == IDLE && start) begin
            dvd_neg <= dividend[WIDTH-1];
            quo_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        end
    end
`else
    assign load_dvd = dividend;
    assign load_dvs = divisor;
    assign fin_q    = q_next;
    assign fin_r    = rem_next;
    assign zero_r   = dvd_r;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (divisor == '0) ? ZERO : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (count_r == '0) state_nxt = DONE;
            end
            ZERO: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Results are written only on the edge entering DONE and then hold until the next start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_r       <= '0;
            dvs_r       <= '0;
            q_r         <= '0;
            rem_r       <= '0;
            count_r     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_r       <= load_dvd;
                        dvs_r       <= load_dvs;
                        q_r         <= load_dvd;
                        rem_r       <= '0;
                        count_r     <= CW'(WIDTH - 1);
                        div_by_zero <= 1'b0;
                    end
                end
                RUN: begin
                    rem_r   <= rem_next;
                    q_r     <= q_next;
                    count_r <= count_r - CW'(1);
                    if (count_r == '0) begin
                        quotient  <= fin_q;
                        remainder <= fin_r;
                    end
                end
                ZERO: begin
                    quotient    <= '1;
                    remainder   <= zero_r;
                    div_by_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed test-plan steps plus random operands
// checked against an arithmetic reference model (signed when SEQ_DIVIDER_SIGNED_EN is defined).
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        int ia, ib;
`ifdef SEQ_DIVIDER_SIGNED_EN
        ia = int'($signed(a));
        ib = int'($signed(b));
`else
        ia = int'(a);
        ib = int'(b);
`endif
        if (ib == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = W'(ia / ib);
            r = W'(ia % ib);
            z = 1'b0;
        end
    endfunction

    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Counts falling edges after the accepted start edge until done; optionally pulses a
    // second start in the middle of the operation
    task automatic wait_done(input string tag, input int exp_lat, input int inject_at);
        int lat;
        bit busy_ok;
        lat     = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!done && !busy) busy_ok = 1'b0;
            if (lat == inject_at) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end else if (lat == inject_at + 1) begin
                start = 1'b0;
            end
        end while (!done && lat < 100);
        start = 1'b0;
        check_output({tag, ".latency"}, lat, exp_lat);
        check_output({tag, ".busy"}, busy_ok, 1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                          input int inject_at);
        apply_stimulus(a, b);
        wait_done(tag, ez ? 2 : W + 1, inject_at);
        check_output({tag, ".quotient"}, quotient, eq);
        check_output({tag, ".remainder"}, remainder, er);
        check_output({tag, ".div_by_zero"}, div_by_zero, ez);
        @(negedge clk);
        check_output({tag, ".done_pulse"}, done, 0);
        check_output({tag, ".idle"}, busy, 0);
        check_output({tag, ".hold"}, quotient, eq);
    endtask

    task automatic run_model_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r;
        logic z;
        model(a, b, q, r, z);
        run_op(tag, a, b, q, r, z, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int gap;
        bit saw_done;
        logic [W-1:0] ra, rb;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check_output("reset.busy", busy, 0);
        check_output("reset.done", done, 0);
        check_output("reset.quotient", quotient, 0);
        check_output("reset.remainder", remainder, 0);
        check_output("reset.div_by_zero", div_by_zero, 0);
        rst_n = 1'b1;

        run_op("15/3", 8'd15, 8'd3, 8'd5, 8'd0, 1'b0, 0);
`ifndef SEQ_DIVIDER_SIGNED_EN
        run_op("200/7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 0);
        run_op("3/15", 8'd3, 8'd15, 8'd0, 8'd3, 1'b0, 0);
        run_op("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 0);
`else
        run_op("-15/4", 8'hF1, 8'd4, 8'hFD, 8'hFD, 1'b0, 0);
        run_op("15/-4", 8'd15, 8'hFC, 8'hFD, 8'd3, 1'b0, 0);
        run_op("-128/-1", 8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, 0);
        run_op("3/15", 8'd3, 8'd15, 8'd0, 8'd3, 1'b0, 0);
`endif
        run_op("5/0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 0);
        run_op("9/2", 8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 0);

        // Second request during RUN must be dropped with no extra done
        run_op("100/9+inject", 8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 3);
        saw_done = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check_output("inject.no_second_done", saw_done, 0);

        apply_stimulus(8'd77, 8'd6);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("abort.busy", busy, 0);
        check_output("abort.done", done, 0);
        check_output("abort.quotient", quotient, 0);
        check_output("abort.remainder", remainder, 0);
        check_output("abort.div_by_zero", div_by_zero, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        repeat (W + 6) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check_output("abort.no_done", saw_done, 0);

        // Start held high: operations follow each other with one IDLE cycle between them
        @(negedge clk);
        dividend = 8'd12;
        divisor  = 8'd4;
        start    = 1'b1;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!done && gap < 100);
        check_output("b2b.first", gap, W + 1);
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!done && gap < 100);
            check_output($sformatf("b2b.gap%0d", k), gap, W + 2);
            check_output($sformatf("b2b.quotient%0d", k), quotient, 3);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_output("b2b.idle", busy, 0);

        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            run_model_op($sformatf("rand%0d", i), ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
